baud_tick_gen: RTL

Programmable fractional-N baud tick generator for the UART TX/RX paths. It replaces a fixed square-wave divider with single-cycle tick pulses: an oversample tick, a mid-bit sample tick and a bit tick. The divisor is runtime-loadable through a valid/ready handshake. A sync input realigns the phase on an RX start-bit edge.

---
 rtl/baud_tick_gen_if.sv | 28 ++
 rtl/baud_tick_gen.sv | 122 ++++++++++++
 2 files changed

// File: rtl/baud_tick_gen_if.sv
// Configuration handshake bundle for baud_tick_gen: divisor offer with valid/ready
// and a one-cycle reject pulse back to the requester.
interface baud_tick_gen_if #(
  parameter int DIV_WIDTH  = 16,
  parameter int FRAC_WIDTH = 4
);
  logic [DIV_WIDTH-1:0]  cfg_int_in;
  logic [FRAC_WIDTH-1:0] cfg_frac_in;
  logic                  cfg_valid_in;
  logic                  cfg_ready_out;
  logic                  cfg_err_out;

  modport master (
    output cfg_int_in,
    output cfg_frac_in,
    output cfg_valid_in,
    input  cfg_ready_out,
    input  cfg_err_out
  );

  modport slave (
    input  cfg_int_in,
    input  cfg_frac_in,
    input  cfg_valid_in,
    output cfg_ready_out,
    output cfg_err_out
  );
endinterface

// File: rtl/baud_tick_gen.sv
// Fractional-N baud tick generator: oversample, mid-bit sample and bit ticks with a
// shadowed, runtime-loadable divisor and a phase-resync input for RX start edges.
module baud_tick_gen #(
  parameter int DIV_WIDTH    = 16,
  parameter int FRAC_WIDTH   = 4,
  parameter int OVERSAMPLING = 8,
  parameter int DEFAULT_INT  = 54,
  parameter int DEFAULT_FRAC = 4
) (
  input  logic                            clk_in,
  input  logic                            nrst_in,
  input  logic                            enable_in,
  input  logic                            sync_in,
  baud_tick_gen_if.slave                  cfg,
  output logic                            os_tick_out,
  output logic                            sample_tick_out,
  output logic                            bit_tick_out,
  output logic [$clog2(OVERSAMPLING)-1:0] os_phase_out
);

  localparam int CNT_W = DIV_WIDTH + 1;
  localparam int PH_W  = $clog2(OVERSAMPLING);
  localparam logic [PH_W-1:0] SAMPLE_PHASE = PH_W'(OVERSAMPLING / 2 - 1);
  localparam logic [PH_W-1:0] BIT_PHASE    = PH_W'(OVERSAMPLING - 1);

  logic [CNT_W-1:0]      cnt;
  logic [FRAC_WIDTH-1:0] acc;
  logic                  carry;
  logic [PH_W-1:0]       phase;

  logic [DIV_WIDTH-1:0]  int_active;
  logic [FRAC_WIDTH-1:0] frac_active;
  logic [DIV_WIDTH-1:0]  int_shadow;
  logic [FRAC_WIDTH-1:0] frac_shadow;
  logic                  shadow_valid;
  logic                  cfg_err_q;

  logic [CNT_W-1:0]      period;
  logic                  terminal;
  logic                  cfg_xfer;
  logic                  cfg_ok;
  logic                  apply_now;
  logic [FRAC_WIDTH:0]   frac_sum;

  always_comb begin
    period    = {1'b0, int_active} + CNT_W'(carry);
    terminal  = (cnt == period - CNT_W'(1));
    cfg_xfer  = cfg.cfg_valid_in && !shadow_valid;
    cfg_ok    = (cfg.cfg_int_in >= DIV_WIDTH'(2));
    frac_sum  = {1'b0, acc} + {1'b0, frac_active};
    // While running, a pending shadow only swaps in on a real (non-synced) boundary.
    apply_now = shadow_valid && (enable_in ? (terminal && !sync_in) : 1'b1);
  end

  always_ff @(posedge clk_in or negedge nrst_in) begin
    if (!nrst_in) begin
      cnt             <= '0;
      acc             <= '0;
      carry           <= 1'b0;
      phase           <= '0;
      os_tick_out     <= 1'b0;
      sample_tick_out <= 1'b0;
      bit_tick_out    <= 1'b0;
    end else begin
      os_tick_out     <= 1'b0;
      sample_tick_out <= 1'b0;
      bit_tick_out    <= 1'b0;
      if (!enable_in || sync_in) begin
        cnt   <= '0;
        acc   <= '0;
        carry <= 1'b0;
        phase <= '0;
      end else if (terminal) begin
        os_tick_out     <= 1'b1;
        sample_tick_out <= (phase == SAMPLE_PHASE);
        bit_tick_out    <= (phase == BIT_PHASE);
        cnt             <= '0;
        phase           <= phase + PH_W'(1);
        // A freshly applied divisor starts with a clean fractional history.
        if (apply_now) begin
          acc   <= '0;
          carry <= 1'b0;
        end else begin
          {carry, acc} <= frac_sum;
        end
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_in or negedge nrst_in) begin
    if (!nrst_in) begin
      int_active   <= DIV_WIDTH'(DEFAULT_INT);
      frac_active  <= FRAC_WIDTH'(DEFAULT_FRAC);
      int_shadow   <= '0;
      frac_shadow  <= '0;
      shadow_valid <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else begin
      cfg_err_q <= 1'b0;
      if (apply_now) begin
        int_active   <= int_shadow;
        frac_active  <= frac_shadow;
        shadow_valid <= 1'b0;
      end else if (cfg_xfer) begin
        if (cfg_ok) begin
          int_shadow   <= cfg.cfg_int_in;
          frac_shadow  <= cfg.cfg_frac_in;
          shadow_valid <= 1'b1;
        end else begin
          cfg_err_q <= 1'b1;
        end
      end
    end
  end

  assign os_phase_out      = phase;
  assign cfg.cfg_ready_out = !shadow_valid;
  assign cfg.cfg_err_out   = cfg_err_q;

endmodule
